// File: rtl/flash_prot_ctrl.sv
// SPI flash status-register lock sequencer: WREN/EWSR, WRSR, RDSR busy poll with timeout, masked SR1 check.
// Owns the flash pins only while rdy=0; go is ignored while busy and nothing is queued.
module flash_prot_ctrl #(
  parameter int         SR_BYTES    = 1,
  parameter int         DIV         = 2,
  parameter int         POLL_MAX    = 1024,
  parameter bit         VOLATILE    = 1'b0,
  parameter logic [7:0] VERIFY_MASK = 8'hFC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  go,
  input  logic [8*SR_BYTES-1:0] sr_val,
  output logic                  rdy,
  output logic                  err,
  output logic                  spi_csn,
  output logic                  spi_sck,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  localparam int         TXW    = 8 * (SR_BYTES + 1);
  localparam int         DW     = $clog2(2 * DIV);
  localparam int         HW     = $clog2(2 * TXW + 2);
  localparam int         PW     = $clog2(POLL_MAX + 1);
  localparam logic [7:0] WEN_OP = VOLATILE ? 8'h50 : 8'h06;

  typedef enum logic [2:0] {S_IDLE, S_WEN, S_GAP, S_WRSR, S_POLL, S_CHECK} state_t;

  state_t                  state_q, state_d, after_q, after_d;
  logic [8*SR_BYTES-1:0]   sr_q, sr_d, sr_msb;
  logic [TXW-1:0]          tx_q, tx_d, load_val;
  logic [7:0]              rx_q, rx_d;
  logic [DW-1:0]           div_q, div_d;
  logic [HW-1:0]           half_q, half_d, last_half;
  logic [PW-1:0]           poll_q, poll_d, poll_inc;
  logic                    err_q, err_d, csn_q, csn_d, sck_q, sck_d, mosi_q, mosi_d;

  // Status bytes go out byte 0 first, so reorder them into the MSB-first shifter.
  always_comb begin
    sr_msb = '0;
    for (int i = 0; i < SR_BYTES; i++) begin
      sr_msb[8*(SR_BYTES-1-i) +: 8] = sr_q[8*i +: 8];
    end
  end

  always_comb begin
    load_val  = '0;
    last_half = '0;
    case (state_q)
      S_WEN: begin
        load_val  = {WEN_OP, {(TXW-8){1'b0}}};
        last_half = HW'(16);
      end
      S_WRSR: begin
        load_val  = {8'h01, sr_msb};
        last_half = HW'(2 * TXW);
      end
      S_POLL: begin
        load_val  = {8'h05, {(TXW-8){1'b0}}};
        last_half = HW'(32);
      end
      default: ;
    endcase
  end

  assign poll_inc = poll_q + 1'b1;

  always_comb begin
    state_d = state_q;
    after_d = after_q;
    sr_d    = sr_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    div_d   = div_q;
    half_d  = half_q;
    poll_d  = poll_q;
    err_d   = err_q;
    csn_d   = csn_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          sr_d    = sr_val;
          err_d   = 1'b0;
          poll_d  = '0;
          state_d = S_WEN;
        end
      end
      // CS stays high 2*DIV-1 cycles here; the transaction state spends one more dropping it.
      S_GAP: begin
        if (div_q == DW'(2 * DIV - 2)) begin
          div_d   = '0;
          state_d = after_q;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_WEN, S_WRSR, S_POLL: begin
        if (csn_q) begin
          csn_d  = 1'b0;
          tx_d   = load_val;
          mosi_d = load_val[TXW-1];
          div_d  = '0;
          half_d = '0;
        end else if (div_q != DW'(DIV - 1)) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d  = '0;
          half_d = half_q + 1'b1;
          if (half_q == last_half) begin
            csn_d   = 1'b1;
            mosi_d  = 1'b0;
            state_d = S_GAP;
            case (state_q)
              S_WEN:  after_d = S_WRSR;
              S_WRSR: after_d = S_POLL;
              default: begin
                poll_d  = poll_inc;
                after_d = S_POLL;
                if (!rx_q[0]) begin
                  state_d = S_CHECK;
                end else if (poll_inc == PW'(POLL_MAX)) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
                end
              end
            endcase
          end else if (!half_q[0]) begin
            sck_d = 1'b1;
            rx_d  = {rx_q[6:0], spi_miso};
          end else begin
            sck_d  = 1'b0;
            tx_d   = tx_q << 1;
            mosi_d = tx_q[TXW-2];
          end
        end
      end
      S_CHECK: begin
        err_d   = |((rx_q ^ sr_q[7:0]) & VERIFY_MASK);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      after_q <= S_IDLE;
      sr_q    <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      div_q   <= '0;
      half_q  <= '0;
      poll_q  <= '0;
      err_q   <= 1'b0;
      csn_q   <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      after_q <= after_d;
      sr_q    <= sr_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      div_q   <= div_d;
      half_q  <= half_d;
      poll_q  <= poll_d;
      err_q   <= err_d;
      csn_q   <= csn_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
    end
  end

  assign rdy      = (state_q == S_IDLE);
  assign err      = err_q;
  assign spi_csn  = csn_q;
  assign spi_sck  = sck_q;
  assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_flash_prot_ctrl.sv
// Directed bench: two configurations, each beside a small SPI flash model that logs MOSI bytes and CS timing.
module tb_flash_prot_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic go0, go1;
  logic [15:0] sr0;
  logic [7:0]  sr1;
  logic rdy0, err0, csn0, sck0, mosi0;
  logic rdy1, err1, csn1, sck1, mosi1;
  logic miso0 = 1'b0;
  logic miso1;
  assign miso1 = 1'b0;

  always #5 clk = ~clk;

  flash_prot_ctrl #(.SR_BYTES(2), .DIV(2), .POLL_MAX(4), .VOLATILE(1'b0), .VERIFY_MASK(8'hFC)) dut0 (
    .clk(clk), .rst_n(rst_n), .go(go0), .sr_val(sr0), .rdy(rdy0), .err(err0),
    .spi_csn(csn0), .spi_sck(sck0), .spi_mosi(mosi0), .spi_miso(miso0));

  flash_prot_ctrl #(.SR_BYTES(1), .DIV(1), .POLL_MAX(1024), .VOLATILE(1'b1), .VERIFY_MASK(8'hFC)) dut1 (
    .clk(clk), .rst_n(rst_n), .go(go1), .sr_val(sr1), .rdy(rdy1), .err(err1),
    .spi_csn(csn1), .spi_sck(sck1), .spi_mosi(mosi1), .spi_miso(miso1));

  int n_pass = 0;
  int n_total = 0;

  // Flash model knobs: polls report WIP=1 until wip_polls of them have completed, then final_sr.
  int         wip_polls = 0;
  int         poll_base = 0;
  logic [7:0] final_sr = 8'h00;

  int         ntrans0 = 0, npolls0 = 0, bitn0 = 0, low_n0 = 0, high_n0 = 0;
  logic [7:0] sh0 = 8'h00, opc0 = 8'h00, stat0;
  logic       csn_p0 = 1'b1, sck_p0 = 1'b0;
  logic [7:0] log0[$];
  int         lows0[$];
  int         gaps0[$];

  always begin
    @(negedge clk);
    if (!csn0 && csn_p0) begin
      gaps0.push_back(high_n0);
      ntrans0 = ntrans0 + 1;
      bitn0 = 0;
      opc0 = 8'h00;
      low_n0 = 0;
    end
    if (csn0 && !csn_p0) begin
      lows0.push_back(low_n0);
      high_n0 = 0;
    end
    if (csn0) high_n0 = high_n0 + 1;
    else low_n0 = low_n0 + 1;
    if (!csn0 && sck0 && !sck_p0) begin
      sh0 = {sh0[6:0], mosi0};
      bitn0 = bitn0 + 1;
      if (bitn0 % 8 == 0) log0.push_back(sh0);
      if (bitn0 == 8) opc0 = sh0;
      if (opc0 == 8'h05 && bitn0 == 16) npolls0 = npolls0 + 1;
    end
    stat0 = ((npolls0 - poll_base) < wip_polls) ? 8'h01 : final_sr;
    miso0 = (opc0 == 8'h05 && bitn0 >= 8 && bitn0 < 16) ? stat0[15 - bitn0] : 1'b0;
    csn_p0 = csn0;
    sck_p0 = sck0;
  end

  int         ntrans1 = 0, bitn1 = 0, low_n1 = 0;
  logic [7:0] sh1 = 8'h00;
  logic       csn_p1 = 1'b1, sck_p1 = 1'b0;
  logic [7:0] log1[$];
  int         lows1[$];

  always begin
    @(negedge clk);
    if (!csn1 && csn_p1) begin
      ntrans1 = ntrans1 + 1;
      bitn1 = 0;
      low_n1 = 0;
    end
    if (csn1 && !csn_p1) lows1.push_back(low_n1);
    if (!csn1) low_n1 = low_n1 + 1;
    if (!csn1 && sck1 && !sck_p1) begin
      sh1 = {sh1[6:0], mosi1};
      bitn1 = bitn1 + 1;
      if (bitn1 % 8 == 0) log1.push_back(sh1);
    end
    csn_p1 = csn1;
    sck_p1 = sck1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int at_q(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic [127:0] pack_bytes(input logic [7:0] q[$], input int base, input int n);
    logic [127:0] r = '0;
    for (int k = 0; k < n; k++) begin
      if (base + k < q.size()) r = {r[119:0], q[base + k]};
    end
    return r;
  endfunction

  task automatic wait_rdy(input bit which, input string tag);
    int c = 0;
    while (!(which ? rdy1 : rdy0) && c < 5000) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_done"}, which ? rdy1 : rdy0, 1);
    @(negedge clk);
  endtask

  task automatic wait_trans0(input int target, input string tag);
    int c = 0;
    while (ntrans0 < target && c < 5000) begin
      @(negedge clk);
      c++;
    end
    chk(tag, ntrans0 >= target, 1);
  endtask

  task automatic pulse_go0();
    go0 = 1'b1;
    @(negedge clk);
    go0 = 1'b0;
  endtask

  int tb, bb, lb, gb, t1;

  initial begin
    rst_n = 1'b0; go0 = 1'b0; go1 = 1'b0; sr0 = 16'h021C; sr1 = 8'h3C;
    repeat (3) @(negedge clk);
    chk("rst_rdy", rdy0, 1);
    chk("rst_err", err0, 0);
    chk("rst_csn", csn0, 1);
    chk("rst_sck", sck0, 0);
    chk("rst_mosi", mosi0, 0);
    chk("rst_rdy_v", rdy1, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Volatile, one SR byte, DIV=1: flash reads back 0x00 so the masked check fails.
    go1 = 1'b1; @(negedge clk); go1 = 1'b0;
    wait_rdy(1'b1, "V");
    chk("V_err", err1, 1);
    chk("V_trans", ntrans1, 3);
    chk("V_bytes", pack_bytes(log1, 0, 5), 40'h50_01_3C_05_00);
    chk("V_wen_low", at_q(lows1, 0), 17);

    // Nominal: WIP for three polls, then 0x1C.
    wip_polls = 3; final_sr = 8'h1C; poll_base = npolls0;
    tb = ntrans0; bb = log0.size(); lb = lows0.size(); gb = gaps0.size();
    pulse_go0();
    chk("A_rdy_low", rdy0, 0);
    chk("A_csn_hold", csn0, 1);
    @(negedge clk);
    chk("A_csn_fall", csn0, 0);
    wait_rdy(1'b0, "A");
    chk("A_err", err0, 0);
    chk("A_trans", ntrans0 - tb, 6);
    chk("A_polls", npolls0 - poll_base, 4);
    chk("A_bytes", pack_bytes(log0, bb, 12), 96'h06_01_1C_02_05_00_05_00_05_00_05_00);
    chk("A_wen_low", at_q(lows0, lb), 34);
    chk("A_wrsr_low", at_q(lows0, lb + 1), 98);
    chk("A_poll_low", at_q(lows0, lb + 2), 66);
    chk("A_gap1", at_q(gaps0, gb + 1), 4);
    chk("A_gap5", at_q(gaps0, gb + 5), 4);

    // Read-back 0x00 mismatches SR1.
    wip_polls = 0; final_sr = 8'h00; poll_base = npolls0; tb = ntrans0;
    pulse_go0();
    wait_rdy(1'b0, "B");
    chk("B_err", err0, 1);
    chk("B_trans", ntrans0 - tb, 3);

    // 0x1E differs only in a masked-out bit; go clears the sticky err on acceptance.
    final_sr = 8'h1E; poll_base = npolls0;
    pulse_go0();
    chk("C_err_clear", err0, 0);
    wait_rdy(1'b0, "C");
    chk("C_err", err0, 0);

    // WIP never clears: POLL_MAX=4 transactions then timeout.
    wip_polls = 1000; poll_base = npolls0; tb = ntrans0;
    pulse_go0();
    wait_rdy(1'b0, "D");
    chk("D_err", err0, 1);
    chk("D_polls", npolls0 - poll_base, 4);
    chk("D_trans", ntrans0 - tb, 6);
    pulse_go0();
    chk("D_err_clear", err0, 0);
    wait_rdy(1'b0, "D2");

    // go during WRSR is ignored; go held through the rdy-rise cycle starts a new run.
    wip_polls = 0; final_sr = 8'h1C; poll_base = npolls0; tb = ntrans0;
    pulse_go0();
    wait_trans0(tb + 2, "E_in_wrsr");
    repeat (5) begin
      go0 = 1'b1; @(negedge clk);
      go0 = 1'b0; @(negedge clk);
    end
    go0 = 1'b1;
    for (int c = 0; c < 5000 && !rdy0; c++) @(negedge clk);
    chk("E_rdy_rise", rdy0, 1);
    t1 = ntrans0 - tb;
    @(negedge clk);
    chk("E_accept", rdy0, 0);
    go0 = 1'b0;
    chk("E_trans", t1, 3);
    wait_rdy(1'b0, "E2");
    chk("E2_err", err0, 0);
    chk("E2_trans", ntrans0 - tb, 6);

    // Reset in the middle of the WRSR transaction.
    pulse_go0();
    go0 = 1'b0;
    wait_trans0(ntrans0 + 1, "F_wen");
    tb = ntrans0;
    wait_trans0(tb + 1, "F_in_wrsr");
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("F_csn", csn0, 1);
    chk("F_sck", sck0, 0);
    chk("F_rdy", rdy0, 1);
    chk("F_err", err0, 0);
    chk("F_mosi", mosi0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    wip_polls = 3; poll_base = npolls0; tb = ntrans0; bb = log0.size();
    pulse_go0();
    wait_rdy(1'b0, "F2");
    chk("F2_err", err0, 0);
    chk("F2_trans", ntrans0 - tb, 6);
    chk("F2_bytes", pack_bytes(log0, bb, 12), 96'h06_01_1C_02_05_00_05_00_05_00_05_00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
